l4_tx_line_buf: RTL and testbench

- Downstream stage of the Lab4 stream-cipher top level, sitting between it and the UART transmitter.
- Captures each byte presented on L4_tx_data/L4_tx_data_rdy into a line FIFO.
- On an L4_PrintBuf pulse, drains the captured line to the UART through a valid/ready handshake. It can optionally append CR LF.
- Decouples the cipher's one-byte-per-cycle bursts from the slower UART.

---
 rtl/l4_pkg.sv | 17 +
 rtl/l4_tx_line_buf_if.sv | 29 ++
 rtl/l4_sync_fifo.sv | 53 +++++
 rtl/l4_tx_line_buf.sv | 127 ++++++++++++
 tb/tb_l4_tx_line_buf.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/l4_pkg.sv
// Shared types and constants for the Lab4 UART line buffer.
// Build option: L4_TXBUF_CRLF_EN terminates every drain with CR LF.
package l4_pkg;

  localparam int unsigned L4_DEPTH = 32;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CR    = 2'd2,
    ST_LF    = 2'd3
  } l4_state_e;

endpackage

// File: rtl/l4_tx_line_buf_if.sv
// Cipher-side capture, print request and UART-side handshake of the line buffer.
interface l4_tx_line_buf_if
  import l4_pkg::*;
#(
  parameter int unsigned DEPTH = L4_DEPTH
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0] in_data;
  logic       in_data_rdy;
  logic       print_buf;
  logic       tx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic [AW:0] count;
  logic       overflow;
  logic       busy;

  modport master (
    output in_data, in_data_rdy, print_buf, tx_ready,
    input  tx_valid, tx_data, count, overflow, busy
  );

  modport slave (
    input  in_data, in_data_rdy, print_buf, tx_ready,
    output tx_valid, tx_data, count, overflow, busy
  );

endinterface

// File: rtl/l4_sync_fifo.sv
// Byte FIFO with registered read port; read address looks ahead on pop so the
// next entry is available one cycle after the pop.
module l4_sync_fifo #(
  parameter  int unsigned DEPTH = 32,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [7:0]    i_wr_data,
  input  logic          i_pop,
  output logic [7:0]    o_rd_data,
  output logic [CW-1:0] o_count,
  output logic          o_full_c
);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [7:0]    r_rd_data;
  logic [AW-1:0] w_rd_addr;

  assign w_rd_addr = i_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_rd_data <= 8'h00;
    end else begin
      r_rd_data <= r_mem[w_rd_addr];
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rd_data = r_rd_data;
  assign o_count   = r_count;
  assign o_full_c  = (r_count == CW'(DEPTH));

endmodule

// File: rtl/l4_tx_line_buf.sv
// Line buffer between the Lab4 cipher and the UART: captures bytes, drains a
// snapshot of them on print. Build option: L4_TXBUF_CRLF_EN appends CR LF.
module l4_tx_line_buf
  import l4_pkg::*;
#(
  parameter int unsigned DEPTH = L4_DEPTH
) (
  input logic              clk,
  input logic              rst,
  l4_tx_line_buf_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [7:0]    w_rd_data;

  l4_state_e     r_state;
  logic [CW-1:0] r_remaining;
  logic          r_tx_valid;
  logic [7:0]    r_tx_data;
  logic          r_overflow;
  logic          r_busy;

  assign w_push = bus.in_data_rdy & ~w_full;
  assign w_pop  = r_tx_valid & bus.tx_ready & (r_state == ST_DRAIN);

  l4_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_wr_data (bus.in_data),
    .i_pop     (w_pop),
    .o_rd_data (w_rd_data),
    .o_count   (w_count),
    .o_full_c  (w_full)
  );

  // Drain sequencer; each byte is loaded one cycle after the previous transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_FILL;
      r_remaining <= '0;
      r_tx_valid  <= 1'b0;
      r_tx_data   <= 8'h00;
      r_overflow  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_FILL: begin
          if (bus.print_buf) begin
            r_remaining <= w_count;
            r_busy      <= 1'b1;
`ifdef L4_TXBUF_CRLF_EN
            r_state     <= (w_count == '0) ? ST_CR : ST_DRAIN;
`else
            r_state     <= ST_DRAIN;
`endif
          end
        end
        ST_DRAIN: begin
          if (!r_tx_valid) begin
            if (r_remaining == '0) begin
              r_state <= ST_FILL;
              r_busy  <= 1'b0;
            end else begin
              r_tx_data  <= w_rd_data;
              r_tx_valid <= 1'b1;
            end
          end else if (bus.tx_ready) begin
            r_tx_valid  <= 1'b0;
            r_remaining <= r_remaining - CW'(1);
            if (r_remaining == CW'(1)) begin
`ifdef L4_TXBUF_CRLF_EN
              r_state    <= ST_CR;
`else
              r_state    <= ST_FILL;
              r_busy     <= 1'b0;
              r_overflow <= 1'b0;
`endif
            end
          end
        end
`ifdef L4_TXBUF_CRLF_EN
        ST_CR: begin
          if (!r_tx_valid) begin
            r_tx_data  <= ASCII_CR;
            r_tx_valid <= 1'b1;
          end else if (bus.tx_ready) begin
            r_tx_valid <= 1'b0;
            r_state    <= ST_LF;
          end
        end
        ST_LF: begin
          if (!r_tx_valid) begin
            r_tx_data  <= ASCII_LF;
            r_tx_valid <= 1'b1;
          end else if (bus.tx_ready) begin
            r_tx_valid <= 1'b0;
            r_state    <= ST_FILL;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
          end
        end
`endif
        default: begin
          r_state    <= ST_FILL;
          r_tx_valid <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
      // A dropped byte outranks the end-of-drain clear.
      if (bus.in_data_rdy && w_full) r_overflow <= 1'b1;
    end
  end

  assign bus.tx_valid = r_tx_valid;
  assign bus.tx_data  = r_tx_data;
  assign bus.count    = w_count;
  assign bus.overflow = r_overflow;
  assign bus.busy     = r_busy;

endmodule

// File: tb/tb_l4_tx_line_buf.sv
// Directed and randomized checks of l4_tx_line_buf against a queue-based line model.
module tb_l4_tx_line_buf;
  import l4_pkg::*;

  localparam int unsigned DEPTH = L4_DEPTH;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  l4_tx_line_buf_if #(.DEPTH(DEPTH)) bus ();

  l4_tx_line_buf #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] model_q[$];
  logic       model_ovf = 1'b0;
  logic [7:0] got_q[$];

`ifdef L4_TXBUF_CRLF_EN
  localparam bit CRLF = 1'b1;
`else
  localparam bit CRLF = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // UART-side monitor: record transfers and check hold-while-stalled.
  logic       hold_prev = 1'b0;
  logic [7:0] hold_data = 8'h00;
  always @(negedge clk) begin
    if (!rst) begin
      hold_prev <= 1'b0;
    end else begin
      if (hold_prev) begin
        total++;
        assert (bus.tx_valid === 1'b1 && bus.tx_data === hold_data) else begin
          bad++;
          $error("FAIL hold_stable: got valid=%0b data=%0h exp valid=1 data=%0h",
                 bus.tx_valid, bus.tx_data, hold_data);
        end
      end
      if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) got_q.push_back(bus.tx_data);
      hold_prev <= (bus.tx_valid === 1'b1) && (bus.tx_ready === 1'b0);
      hold_data <= bus.tx_data;
    end
  end

  task automatic push_byte(input logic [7:0] b);
    bus.in_data     = b;
    bus.in_data_rdy = 1'b1;
    if (model_q.size() < DEPTH) model_q.push_back(b);
    else model_ovf = 1'b1;
    @(posedge clk); #1;
    bus.in_data_rdy = 1'b0;
  endtask

  function automatic logic ready_for(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 2) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  // Print, drain with the chosen tx_ready pattern, then compare against the model.
  task automatic do_print(input string tag, input int mode, input bit mid_push,
                          input logic [7:0] mid_byte);
    logic [7:0] exp_q[$];
    int n;
    n = model_q.size();
    got_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(model_q.pop_front());
    if (CRLF) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
    bus.print_buf = 1'b1;
    bus.tx_ready  = ready_for(mode, 0);
    @(posedge clk); #1;
    bus.print_buf = 1'b0;
    for (int cyc = 1; cyc < 3000; cyc++) begin
      bus.tx_ready = ready_for(mode, cyc);
      if (mid_push && cyc == 3) begin
        bus.in_data     = mid_byte;
        bus.in_data_rdy = 1'b1;
        model_q.push_back(mid_byte);
      end
      @(posedge clk); #1;
      bus.in_data_rdy = 1'b0;
      if (cyc >= 4 && bus.busy === 1'b0 && got_q.size() >= exp_q.size()) break;
    end
    bus.tx_ready = 1'b0;
    if (n > 0 || CRLF) model_ovf = 1'b0;
    check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    end
    check({tag, "_busy"}, 32'(bus.busy), 32'(0));
    check({tag, "_valid"}, 32'(bus.tx_valid), 32'(0));
    check({tag, "_count"}, 32'(bus.count), 32'(model_q.size()));
    check({tag, "_ovf"}, 32'(bus.overflow), 32'(model_ovf));
  endtask

  initial begin
    bus.in_data     = 8'h00;
    bus.in_data_rdy = 1'b0;
    bus.print_buf   = 1'b0;
    bus.tx_ready    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus.tx_valid), 32'(0));
    check("rst_data",  32'(bus.tx_data),  32'(0));
    check("rst_count", 32'(bus.count),    32'(0));
    check("rst_ovf",   32'(bus.overflow), 32'(0));
    check("rst_busy",  32'(bus.busy),     32'(0));
    rst = 1'b1;
    @(posedge clk); #1;

    // ABC with tx_ready held high
    push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
    check("abc_count_pre", 32'(bus.count), 32'(3));
    do_print("abc_rdy", 0, 1'b0, 8'h00);

    // Same line with tx_ready toggling
    push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
    do_print("abc_toggle", 1, 1'b0, 8'h00);

    // Overflow: 33 bytes into a 32-entry FIFO
    for (int i = 0; i <= 32; i++) push_byte(8'(i));
    check("ovf_count", 32'(bus.count), 32'(DEPTH));
    check("ovf_flag",  32'(bus.overflow), 32'(1));
    do_print("ovf_drain", 0, 1'b0, 8'h00);

    // Byte pushed during a drain waits for the next print
    push_byte(8'h31); push_byte(8'h32);
    do_print("mid1", 1, 1'b1, 8'h58);
    do_print("mid2", 0, 1'b0, 8'h00);

    // Empty print
    do_print("empty", 0, 1'b0, 8'h00);

    // Asynchronous reset after the first of three bytes
    push_byte(8'h61); push_byte(8'h62); push_byte(8'h63);
    got_q.delete();
    bus.tx_ready  = 1'b1;
    bus.print_buf = 1'b1;
    @(posedge clk); #1;
    bus.print_buf = 1'b0;
    for (int cyc = 0; cyc < 100 && got_q.size() < 1; cyc++) begin
      @(posedge clk); #1;
    end
    #1;
    rst = 1'b0;
    #1;
    check("arst_valid", 32'(bus.tx_valid), 32'(0));
    check("arst_count", 32'(bus.count),    32'(0));
    check("arst_busy",  32'(bus.busy),     32'(0));
    check("arst_sent",  32'(got_q.size()), 32'(1));
    if (got_q.size() > 0) check("arst_first", 32'(got_q[0]), 32'(8'h61));
    model_q.delete();
    model_ovf = 1'b0;
    bus.tx_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("arst_count_after", 32'(bus.count), 32'(0));
    do_print("arst_print", 0, 1'b0, 8'h00);

    // Randomized lines, some overflowing, with random tx_ready patterns
    for (int it = 0; it < 8; it++) begin
      int len;
      len = $urandom_range(0, 40);
      for (int i = 0; i < len; i++) push_byte(8'($urandom));
      check($sformatf("rnd%0d_count_pre", it), 32'(bus.count), 32'(model_q.size()));
      check($sformatf("rnd%0d_ovf_pre", it), 32'(bus.overflow), 32'(model_ovf));
      do_print($sformatf("rnd%0d", it), int'($urandom_range(0, 2)), 1'b0, 8'h00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
